// File: rtl/spdif_tx.sv
// S/PDIF (IEC 60958) transmitter: stereo sample FIFO, channel-status insertion, BMC line coder.
// Define SPDIF_TX_USER_EN to add user_i, which drives the U timeslot of frames 0..31.
module spdif_tx #(
  parameter int unsigned AUDIO_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          bit_out_en_i,
  input  logic                          enable_i,
  input  logic                          sample_valid_i,
  output logic                          sample_ready_o,
  input  logic [AUDIO_WIDTH-1:0]        sample_l_i,
  input  logic [AUDIO_WIDTH-1:0]        sample_r_i,
  input  logic [31:0]                   chstat_i,
`ifdef SPDIF_TX_USER_EN
  input  logic [31:0]                   user_i,
`endif
  output logic                          spdif_o,
  output logic                          underrun_o,
  output logic                          block_start_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_STOP   = 2'd2;

  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  logic [1:0]             state_q, state_d;
  logic [AUDIO_WIDTH-1:0] fifo_l [FIFO_DEPTH];
  logic [AUDIO_WIDTH-1:0] fifo_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   ready_q;
  logic [5:0]             hb_q;
  logic                   sub_r_q;
  logic [7:0]             frame_q, frame_inc, lframe;
  logic [31:0]            word_q, r_word_q, word_l_new, word_r_new;
  logic                   spdif_q, inv_q, line_d;
  logic                   emit, latch_l, latch_r, to_idle, last_hb;
  logic                   push, pop, fifo_empty, c_bit, u_bit;
  logic [7:0]             pre_sel;

  // Subframe word: audio MSB-aligned to slot 27, V/U/C flags, even parity over slots 4..30.
  function automatic logic [31:0] build_word(input logic [AUDIO_WIDTH-1:0] audio,
                                             input logic v, input logic u, input logic c);
    logic [31:0] w;
    w = '0;
    w[27 -: AUDIO_WIDTH] = audio;
    w[28] = v;
    w[29] = u;
    w[30] = c;
    w[31] = ^w[30:4];
    return w;
  endfunction

  always_comb begin
    state_d    = state_q;
    emit       = 1'b0;
    latch_l    = 1'b0;
    latch_r    = 1'b0;
    to_idle    = 1'b0;
    last_hb    = (hb_q == 6'd63);
    fifo_empty = (level_q == '0);
    frame_inc  = (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
    lframe     = (state_q == ST_IDLE) ? 8'd0 : frame_inc;

    case (state_q)
      ST_IDLE: begin
        if (bit_out_en_i && enable_i) begin
          state_d = ST_ACTIVE;
          latch_l = 1'b1;
        end
      end
      ST_ACTIVE, ST_STOP: begin
        if (bit_out_en_i) begin
          emit = 1'b1;
          if (state_q == ST_ACTIVE && !enable_i) state_d = ST_STOP;
          if (last_hb && !sub_r_q) begin
            latch_r = 1'b1;
          end else if (last_hb && sub_r_q) begin
            if (state_d == ST_STOP) begin
              state_d = ST_IDLE;
              to_idle = 1'b1;
            end else begin
              latch_l = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    push    = sample_valid_i && ready_q;
    pop     = latch_l && !fifo_empty;
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);

    c_bit = (lframe < 8'd32) ? chstat_i[lframe[4:0]] : 1'b0;
`ifdef SPDIF_TX_USER_EN
    u_bit = (lframe < 8'd32) ? user_i[lframe[4:0]] : 1'b0;
`else
    u_bit = 1'b0;
`endif
    word_l_new = fifo_empty ? build_word('0, 1'b1, u_bit, c_bit)
                            : build_word(fifo_l[rd_ptr_q], 1'b0, u_bit, c_bit);
    word_r_new = fifo_empty ? build_word('0, 1'b1, u_bit, c_bit)
                            : build_word(fifo_r[rd_ptr_q], 1'b0, u_bit, c_bit);

    // Preamble polarity follows the line level just before half-bit 0.
    pre_sel = sub_r_q ? PRE_W : ((frame_q == 8'd0) ? PRE_B : PRE_M);
    if (hb_q < 6'd8) begin
      line_d = pre_sel[~hb_q[2:0]] ^ ((hb_q == 6'd0) ? spdif_q : inv_q);
    end else if (!hb_q[0]) begin
      line_d = ~spdif_q;
    end else begin
      line_d = word_q[hb_q[5:1]] ? ~spdif_q : spdif_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Sample storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_l[wr_ptr_q] <= sample_l_i;
      fifo_r[wr_ptr_q] <= sample_r_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      ready_q       <= 1'b1;
      hb_q          <= '0;
      sub_r_q       <= 1'b0;
      frame_q       <= '0;
      word_q        <= '0;
      r_word_q      <= '0;
      spdif_q       <= 1'b0;
      inv_q         <= 1'b0;
      underrun_o    <= 1'b0;
      block_start_o <= 1'b0;
    end else begin
      underrun_o    <= latch_l && fifo_empty;
      block_start_o <= latch_l && (lframe == 8'd0);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      ready_q <= (level_d != LVL_W'(FIFO_DEPTH));

      if (state_q == ST_IDLE) spdif_q <= 1'b0;
      else if (emit)          spdif_q <= line_d;

      if (emit) begin
        hb_q <= hb_q + 6'd1;
        if (hb_q == 6'd0) inv_q <= spdif_q;
        if (last_hb) sub_r_q <= ~sub_r_q;
      end
      if (latch_l) begin
        word_q   <= word_l_new;
        r_word_q <= word_r_new;
        frame_q  <= lframe;
      end
      if (latch_r) word_q <= r_word_q;
      if (to_idle) begin
        frame_q <= '0;
        hb_q    <= '0;
        sub_r_q <= 1'b0;
      end
    end
  end

  assign spdif_o        = spdif_q;
  assign sample_ready_o = ready_q;
  assign fifo_level_o   = level_q;

endmodule

// File: tb/tb_spdif_tx.sv
// Directed bench for spdif_tx (AUDIO_WIDTH=16): decodes the BMC line per subframe and
// compares preambles, timeslot words, FIFO level and pulse counts against hand-computed values.
module tb_spdif_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic        strobe;
  logic        enable;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] sample_l, sample_r;
  logic [31:0] chstat;
  logic        spdif;
  logic        underrun;
  logic        block_start;
  logic [2:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;
  int n_bs     = 0;
  int n_ur     = 0;
  logic prev_line = 1'b0;

  spdif_tx #(.AUDIO_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bit_out_en_i   (strobe),
    .enable_i       (enable),
    .sample_valid_i (sample_valid),
    .sample_ready_o (sample_ready),
    .sample_l_i     (sample_l),
    .sample_r_i     (sample_r),
    .chstat_i       (chstat),
    .spdif_o        (spdif),
    .underrun_o     (underrun),
    .block_start_o  (block_start),
    .fifo_level_o   (fifo_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (block_start) n_bs++;
    if (underrun)    n_ur++;
  end

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [7:0]  pre_l;
    logic [31:0] wl;
    logic [31:0] wr;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_strobe();
    @(negedge clk);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  // 64 strobes; returns the preamble relative to the prior line level and the decoded slots 4..31.
  task automatic capture_sub(input int drop_at, input bit push_last,
                             input logic [15:0] pl, input logic [15:0] pr,
                             output logic [31:0] word, output logic [7:0] pre,
                             output bit bmc_ok);
    logic [63:0] lv;
    lv = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == drop_at) enable = 1'b0;
      if (push_last && i == 63) begin
        sample_valid = 1'b1;
        sample_l     = pl;
        sample_r     = pr;
      end
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
      if (push_last && i == 63) sample_valid = 1'b0;
      lv[i] = spdif;
    end
    pre    = '0;
    word   = '0;
    bmc_ok = 1'b1;
    for (int i = 0; i < 8; i++) pre[7-i] = lv[i] ^ prev_line;
    for (int s = 4; s < 32; s++) begin
      if (lv[2*s] == lv[2*s-1]) bmc_ok = 1'b0;
      word[s] = lv[2*s] ^ lv[2*s+1];
    end
    prev_line = lv[63];
  endtask

  initial begin
    logic [31:0] wl, wr;
    logic [7:0]  pl, pr;
    bit          okl, okr;
    bit          idle_ok;

    tbl[0] = '{l: 16'h8001, r: 16'h0001, pre_l: 8'hE8, wl: 32'hC8001000, wr: 32'h40001000};
    tbl[1] = '{l: 16'h1234, r: 16'hFFFF, pre_l: 8'hE2, wl: 32'h81234000, wr: 32'h0FFFF000};
    tbl[2] = '{l: 16'h0000, r: 16'h7FFF, pre_l: 8'hE2, wl: 32'hC0000000, wr: 32'h47FFF000};
    tbl[3] = '{l: 16'hA5A5, r: 16'h0F00, pre_l: 8'hE2, wl: 32'h0A5A5000, wr: 32'h00F00000};
    tbl[4] = '{l: 16'h0003, r: 16'h8000, pre_l: 8'hE2, wl: 32'h00003000, wr: 32'h88000000};

    rst = 1'b1; strobe = 1'b0; enable = 1'b0; sample_valid = 1'b0;
    sample_l = '0; sample_r = '0; chstat = 32'h0000_0005;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_spdif", 32'(spdif), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_block_start", 32'(block_start), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);

    // Fill the FIFO with no strobes, then offer one more pair while full.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_l = tbl[k].l;
      sample_r = tbl[k].r;
    end
    @(negedge clk);
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_ready", 32'(sample_ready), 32'd0);
    sample_l = 16'hDEAD;
    @(negedge clk);
    sample_valid = 1'b0;
    check("full_no_push", 32'(fifo_level), 32'd4);

    enable = 1'b1;
    pulse_strobe();
    check("start_level", 32'(fifo_level), 32'd3);
    @(negedge clk);
    check("start_block_pulses", 32'(n_bs), 32'd1);

    for (int f = 0; f < 5; f++) begin
      capture_sub(-1, 1'b0, '0, '0, wl, pl, okl);
      capture_sub(-1, (f == 0), tbl[4].l, tbl[4].r, wr, pr, okr);
      check($sformatf("f%0d_pre_l", f), 32'(pl), 32'(tbl[f].pre_l));
      check($sformatf("f%0d_pre_r", f), 32'(pr), 32'hE4);
      check($sformatf("f%0d_word_l", f), wl, tbl[f].wl);
      check($sformatf("f%0d_word_r", f), wr, tbl[f].wr);
      check($sformatf("f%0d_bmc", f), 32'({okl, okr}), 32'd3);
      if (f == 0) check("push_pop_level", 32'(fifo_level), 32'd3);
      if (f == 3) check("drained_level", 32'(fifo_level), 32'd0);
    end

    // Frame 5 was latched from an empty FIFO.
    capture_sub(-1, 1'b0, '0, '0, wl, pl, okl);
    check("ur_pulses", 32'(n_ur), 32'd1);
    check("ur_word_l", wl, 32'h90000000);
    check("ur_bmc_l", 32'(okl), 32'd1);
    @(negedge clk);
    sample_valid = 1'b1; sample_l = 16'h0001; sample_r = 16'h0002;
    @(negedge clk);
    sample_valid = 1'b0;
    check("refill_level", 32'(fifo_level), 32'd1);
    capture_sub(-1, 1'b0, '0, '0, wr, pr, okr);
    check("ur_word_r", wr, 32'h90000000);
    check("ur_pre_r", 32'(pr), 32'hE4);

    capture_sub(-1, 1'b0, '0, '0, wl, pl, okl);
    check("resume_word_l", wl, 32'h80001000);
    // Continuous zero feed from here on keeps the FIFO non-empty.
    sample_valid = 1'b1; sample_l = '0; sample_r = '0;
    capture_sub(-1, 1'b0, '0, '0, wr, pr, okr);
    check("resume_word_r", wr, 32'h80002000);
    check("resume_ur_pulses", 32'(n_ur), 32'd1);

    for (int f = 7; f < 192; f++) begin
      capture_sub(-1, 1'b0, '0, '0, wl, pl, okl);
      capture_sub(-1, 1'b0, '0, '0, wr, pr, okr);
      check($sformatf("f%0d_pre", f), {16'd0, pl, pr}, 32'h0000E2E4);
      check($sformatf("f%0d_words", f), wl | wr, 32'd0);
      check($sformatf("f%0d_bmc", f), 32'({okl, okr}), 32'd3);
    end

    // Frame 192 wraps to block start; drop enable part-way through its L subframe.
    capture_sub(20, 1'b0, '0, '0, wl, pl, okl);
    check("wrap_pre_l", 32'(pl), 32'hE8);
    check("wrap_word_l", wl, 32'hC0000000);
    check("wrap_block_pulses", 32'(n_bs), 32'd2);
    capture_sub(-1, 1'b0, '0, '0, wr, pr, okr);
    check("stop_pre_r", 32'(pr), 32'hE4);
    check("stop_word_r", wr, 32'hC0000000);
    check("stop_bmc", 32'({okl, okr}), 32'd3);
    idle_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pulse_strobe();
      if (spdif !== 1'b0) idle_ok = 1'b0;
    end
    check("stop_idle_line", 32'(idle_ok), 32'd1);
    check("stop_no_block", 32'(n_bs), 32'd2);
    check("stop_ur_pulses", 32'(n_ur), 32'd1);

    enable = 1'b1;
    prev_line = 1'b0;
    pulse_strobe();
    capture_sub(-1, 1'b0, '0, '0, wl, pl, okl);
    check("restart_pre_l", 32'(pl), 32'hE8);
    check("restart_word_l", wl, 32'hC0000000);
    check("restart_block_pulses", 32'(n_bs), 32'd3);

    // First half-bit of preamble W drives the line high; reset must clear it without a clock edge.
    sample_valid = 1'b0;
    pulse_strobe();
    check("pre_rst_line", 32'(spdif), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_line", 32'(spdif), 32'd0);
    check("async_rst_level", 32'(fifo_level), 32'd0);
    check("async_rst_ready", 32'(sample_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    pulse_strobe();
    check("post_rst_line", 32'(spdif), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spdif_tx.md
Name: spdif_tx

Overview:
Parametrised S/PDIF (IEC 60958) transmitter and successor to the fixed 16-bit core. Supports configurable sample width, a stereo sample FIFO with valid/ready handshake, a channel-status word, correct even parity, underrun signalling with the validity flag, and clean start/stop control. It sits between the audio sample source and the S/PDIF output pad, timed by an external half-bit-rate strobe.

Parameters:
AUDIO_WIDTH, 24, sample bits per channel (16..24); MSB placed in timeslot 27, unused low slots zero
FIFO_DEPTH, 4, stereo-pair FIFO entries (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
bit_out_en_i  in  1  single-cycle strobe at 2x bit rate (44.1k: 5.6448 MHz, 48k: 6.144 MHz)
enable_i  in  1  transmit enable (level)
sample_valid_i  in  1  stereo pair offered
sample_ready_o  out  1  FIFO can accept (= !full)
sample_l_i  in  AUDIO_WIDTH  left sample
sample_r_i  in  AUDIO_WIDTH  right sample
chstat_i  in  32  channel-status bits for frames 0..31 (bit n -> frame n)
spdif_o  out  1  BMC line output, registered
underrun_o  out  1  1-cycle pulse: frame sent with no sample available
block_start_o  out  1  1-cycle pulse when frame 0 subframe L word is latched
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: spdif_o=0, underrun_o=0, block_start_o=0, FIFO empty, fifo_level_o=0, sample_ready_o=1, state IDLE, frame counter 0, half-bit counter 0.
- FIFO write: push when sample_valid_i && sample_ready_o. Push and pop in the same cycle is allowed when not full; level is unchanged. A write while full is impossible because ready=0.
- States:
  - IDLE: spdif_o held at 0, counters at 0. The first strobe with enable_i=1 latches the frame-0 L word and moves to ACTIVE. The first half-bit is emitted on the next strobe.
  - ACTIVE: 64 half-bits per subframe, counter 0..63, advanced only on strobes.
  - STOP: entered when enable_i=0 is sampled on any strobe in ACTIVE. The current frame (L and R) finishes, then the block returns to IDLE. The frame counter resets to 0, so a restart always begins with preamble B.
- Word latch: the next subframe word is latched on the strobe emitting half-bit 63 of the previous subframe, or on the IDLE exit strobe.
  - L latch: pop the FIFO if non-empty and hold R internally.
  - If the FIFO is empty: both subframes of that frame carry audio 0 with V=1, and underrun_o pulses once (cycle after the strobe).
- Word layout (timeslots 0..31):
  - 0-3: preamble.
  - 4-27: audio, LSB first, MSB at slot 27.
  - 28: V (0 normally).
  - 29: U = 0.
  - 30: C = chstat_i[frame] if frame<32, else 0; sampled at latch, same value for L and R.
  - 31: P = XOR of slots 4..30 (even parity).
- Frame counter 0..191: increments after each R subframe and wraps 191->0. block_start_o pulses at the frame-0 L latch.
- Preamble (8 half-bits, first-sent first, for line level 0 before the preamble):
  - B (frame 0 L) = 11101000.
  - M (other L) = 11100010.
  - W (R) = 11100100.
  - The whole pattern is inverted if spdif_o=1 when half-bit 0 is emitted.
- BMC for slots 4..31: the first half toggles the line. The second half toggles if the bit is 1, otherwise holds.
- spdif_o changes only in the cycle after a strobe. The latency from strobe to new level is 1 clk.
- Reset mid-subframe: immediate return to reset values. FIFO contents are discarded.

Optional Feature:
SPDIF_TX_USER_EN.
- Defined: adds input user_i[31:0]. The U slot = user_i[frame] for frame<32, else 0, sampled like C and included in parity.
- Undefined: port absent and U=0.

Test Plan:
1. AUDIO_WIDTH=16, push L=0x8001, R=0x0001, enable -> decoded L slots 12..27 = 0x8001, slots 4..11 = 0; R = 0x0001; P makes slots 4..31 even; first preamble = B (11101000).
2. Continuous FIFO feed for 385 subframes -> preamble B only at frames 0 and 192; block_start_o pulses exactly twice; M/W alternate otherwise.
3. chstat_i=0x00000005 -> C=1 in frames 0 and 2 (both channels), 0 in frames 1, 3..191.
4. Empty FIFO at an L latch -> underrun_o one pulse; both subframes audio 0, V=1, parity still even; next push resumes V=0 on the following frame.
5. Fill 4 pairs with no strobes -> fifo_level_o=4, sample_ready_o=0; simultaneous push/pop at level 3 -> level stays 3.
6. Drop enable_i mid-L subframe -> R subframe completes, spdif_o returns to 0 in IDLE; re-enable -> next frame starts with preamble B; rst_i asserted mid-subframe -> spdif_o=0 immediately.
